// File: rtl/mmc_chan_cmd_sched_if.sv
// mmc_chan_cmd_sched_if: requester handshakes, DFI command slot and issue
// strobe of one channel scheduler. master = requesters/DFI, slave = scheduler.
interface mmc_chan_cmd_sched_if #(
  parameter int BANK_W = 5,
  parameter int PAGE_W = 12,
  parameter int LINE_W = 6
);
  logic              dfi__mmc__init_done;

  logic              rq0__sched__valid;
  logic              rq0__sched__wr;
  logic [BANK_W-1:0] rq0__sched__bank;
  logic [PAGE_W-1:0] rq0__sched__page;
  logic [LINE_W-1:0] rq0__sched__line;
  logic              sched__rq0__ready;

  logic              rq1__sched__valid;
  logic              rq1__sched__wr;
  logic [BANK_W-1:0] rq1__sched__bank;
  logic [PAGE_W-1:0] rq1__sched__page;
  logic [LINE_W-1:0] rq1__sched__line;
  logic              sched__rq1__ready;

  logic              mmc__dfi__cs;
  logic              mmc__dfi__cmd1;
  logic              mmc__dfi__cmd0;
  logic [BANK_W-1:0] mmc__dfi__bank;
  logic [PAGE_W-1:0] mmc__dfi__addr;

  logic              sched__issue_valid;
  logic              sched__issue_rq;
  logic              sched__issue_wr;

  modport master (
    output dfi__mmc__init_done,
    output rq0__sched__valid, rq0__sched__wr,
    output rq0__sched__bank, rq0__sched__page, rq0__sched__line,
    input  sched__rq0__ready,
    output rq1__sched__valid, rq1__sched__wr,
    output rq1__sched__bank, rq1__sched__page, rq1__sched__line,
    input  sched__rq1__ready,
    input  mmc__dfi__cs, mmc__dfi__cmd1, mmc__dfi__cmd0,
    input  mmc__dfi__bank, mmc__dfi__addr,
    input  sched__issue_valid, sched__issue_rq, sched__issue_wr
  );

  modport slave (
    input  dfi__mmc__init_done,
    input  rq0__sched__valid, rq0__sched__wr,
    input  rq0__sched__bank, rq0__sched__page, rq0__sched__line,
    output sched__rq0__ready,
    input  rq1__sched__valid, rq1__sched__wr,
    input  rq1__sched__bank, rq1__sched__page, rq1__sched__line,
    output sched__rq1__ready,
    output mmc__dfi__cs, mmc__dfi__cmd1, mmc__dfi__cmd0,
    output mmc__dfi__bank, mmc__dfi__addr,
    output sched__issue_valid, sched__issue_rq, sched__issue_wr
  );
endinterface

// File: rtl/mmc_chan_cmd_sched.sv
// mmc_chan_cmd_sched: per-channel DRAM command scheduler. Round-robin over two
// requesters, open-page table per bank, PC/PO/RD/WR sequencing with spacing.
// Ports: clk, reset_poweron (async, active-high), bus (slave modport).
module mmc_chan_cmd_sched #(
  parameter int BANK_W = 5,
  parameter int PAGE_W = 12,
  parameter int LINE_W = 6,
  parameter int T_PO   = 4,
  parameter int T_PC   = 3,
  parameter int T_GAP  = 1
) (
  input  logic                clk,
  input  logic                reset_poweron,
  mmc_chan_cmd_sched_if.slave bus
);
  localparam int NB    = 1 << BANK_W;
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE, CLOSE, PC_WAIT, OPEN, PO_WAIT, ACCESS, GAP
  } state_t;

  typedef struct packed {
    logic              rq;
    logic              wr;
    logic [BANK_W-1:0] bank;
    logic [PAGE_W-1:0] page;
    logic [LINE_W-1:0] line;
  } req_t;

  state_t            st_q, st_d;
  req_t              req_q, req_d, req_in;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q;
  logic [NB-1:0]     open_q;
  logic [PAGE_W-1:0] page_q [NB];

  logic              v0, v1, g0, g1;
  logic              rdy_en, acc, hit;
  logic              cs_d, iv_d;
  logic [1:0]        cmd_d;
  logic [BANK_W-1:0] bank_d;
  logic [PAGE_W-1:0] addr_d;

  assign v0 = bus.rq0__sched__valid;
  assign v1 = bus.rq1__sched__valid;

  // last_q = 1 means rq1 was served last, so rq0 wins a tie
  assign g0 = v0 & (~v1 | last_q);
  assign g1 = v1 & (~v0 | ~last_q);

  assign rdy_en = (st_q == IDLE) & bus.dfi__mmc__init_done
                & ~reset_poweron;
  assign acc    = rdy_en & (g0 | g1);

  assign bus.sched__rq0__ready = rdy_en & g0;
  assign bus.sched__rq1__ready = rdy_en & g1;

  always_comb begin
    req_in = '0;
    if (g1) begin
      req_in.rq   = 1'b1;
      req_in.wr   = bus.rq1__sched__wr;
      req_in.bank = bus.rq1__sched__bank;
      req_in.page = bus.rq1__sched__page;
      req_in.line = bus.rq1__sched__line;
    end else begin
      req_in.rq   = 1'b0;
      req_in.wr   = bus.rq0__sched__wr;
      req_in.bank = bus.rq0__sched__bank;
      req_in.page = bus.rq0__sched__page;
      req_in.line = bus.rq0__sched__line;
    end
  end

  assign hit = open_q[req_in.bank]
             & (page_q[req_in.bank] == req_in.page);

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    req_d = req_q;
    unique case (st_q)
      IDLE: begin
        if (acc) begin
          req_d = req_in;
          if (!open_q[req_in.bank]) st_d = OPEN;
          else if (hit)             st_d = ACCESS;
          else                      st_d = CLOSE;
        end
      end
      CLOSE: begin
        if (T_PC == 0) begin
          st_d = OPEN;
        end else begin
          st_d  = PC_WAIT;
          cnt_d = CNT_W'(T_PC - 1);
        end
      end
      PC_WAIT: begin
        if (cnt_q == '0) st_d = OPEN;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      OPEN: begin
        if (T_PO == 0) begin
          st_d = ACCESS;
        end else begin
          st_d  = PO_WAIT;
          cnt_d = CNT_W'(T_PO - 1);
        end
      end
      PO_WAIT: begin
        if (cnt_q == '0) st_d = ACCESS;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      ACCESS: begin
        if (T_GAP == 0) begin
          st_d = IDLE;
        end else begin
          st_d  = GAP;
          cnt_d = CNT_W'(T_GAP - 1);
        end
      end
      GAP: begin
        if (cnt_q == '0) st_d = IDLE;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      default: st_d = IDLE;
    endcase
  end

  // Outputs are registered, so decode the state being entered
  always_comb begin
    cs_d   = 1'b0;
    iv_d   = 1'b0;
    cmd_d  = 2'b00;
    bank_d = '0;
    addr_d = '0;
    unique case (st_d)
      CLOSE: begin
        cs_d   = 1'b1;
        cmd_d  = 2'b01;
        bank_d = req_d.bank;
      end
      OPEN: begin
        cs_d   = 1'b1;
        cmd_d  = 2'b00;
        bank_d = req_d.bank;
        addr_d = req_d.page;
      end
      ACCESS: begin
        cs_d   = 1'b1;
        iv_d   = 1'b1;
        cmd_d  = {1'b1, req_d.wr};
        bank_d = req_d.bank;
        addr_d = PAGE_W'(req_d.line);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      st_q                   <= IDLE;
      cnt_q                  <= '0;
      req_q                  <= '0;
      last_q                 <= 1'b1;
      bus.mmc__dfi__cs       <= 1'b0;
      bus.mmc__dfi__cmd1     <= 1'b0;
      bus.mmc__dfi__cmd0     <= 1'b0;
      bus.mmc__dfi__bank     <= '0;
      bus.mmc__dfi__addr     <= '0;
      bus.sched__issue_valid <= 1'b0;
      bus.sched__issue_rq    <= 1'b0;
      bus.sched__issue_wr    <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      req_q <= req_d;
      if (acc) last_q <= g1;
      bus.mmc__dfi__cs       <= cs_d;
      bus.mmc__dfi__cmd1     <= cmd_d[1];
      bus.mmc__dfi__cmd0     <= cmd_d[0];
      bus.mmc__dfi__bank     <= bank_d;
      bus.mmc__dfi__addr     <= addr_d;
      bus.sched__issue_valid <= iv_d;
      bus.sched__issue_rq    <= iv_d & req_d.rq;
      bus.sched__issue_wr    <= iv_d & req_d.wr;
    end
  end

  // Page table: PC closes the bank, PO opens it on the held page
  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      open_q <= '0;
      for (int i = 0; i < NB; i++) page_q[i] <= '0;
    end else begin
      if (st_q == CLOSE) open_q[req_q.bank] <= 1'b0;
      if (st_q == OPEN) begin
        open_q[req_q.bank] <= 1'b1;
        page_q[req_q.bank] <= req_q.page;
      end
    end
  end
endmodule

// File: tb/tb_mmc_chan_cmd_sched.sv
// tb_mmc_chan_cmd_sched: directed bench with a command scoreboard built
// from the published command timing and an independent page-table model.
module tb_mmc_chan_cmd_sched;
  localparam int BW   = 5;
  localparam int PW   = 12;
  localparam int LW   = 6;
  localparam int TPO  = 4;
  localparam int TPC  = 3;
  localparam int TGAP = 1;

  typedef struct {
    logic [1:0]    cmd;
    logic [BW-1:0] bank;
    logic [PW-1:0] addr;
    int            cyc;
    logic          iv;
    logic          irq;
    logic          iwr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   vec = 0;
  int   miss = 0;

  exp_t          q[$];
  bit            mopen [32];
  logic [PW-1:0] mpage [32];
  bit            last_m = 1'b1;
  int            nxt_ready = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mmc_chan_cmd_sched_if #(.BANK_W(BW), .PAGE_W(PW), .LINE_W(LW)) bus ();

  mmc_chan_cmd_sched #(
    .BANK_W(BW), .PAGE_W(PW), .LINE_W(LW),
    .T_PO(TPO), .T_PC(TPC), .T_GAP(TGAP)
  ) dut (
    .clk(clk),
    .reset_poweron(rst),
    .bus(bus.slave)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(logic [1:0] c, logic [BW-1:0] b, logic [PW-1:0] a,
                      int t, logic iv, logic irq, logic iwr);
    exp_t e;
    e.cmd = c; e.bank = b; e.addr = a; e.cyc = t;
    e.iv = iv; e.irq = irq; e.iwr = iwr;
    q.push_back(e);
  endtask

  // Expected DFI traffic for a request accepted in cycle n
  task automatic model_accept(bit r, bit wr, logic [BW-1:0] b,
                              logic [PW-1:0] p, logic [LW-1:0] l, int n);
    int t;
    int a;
    if (mopen[b] && mpage[b] == p) begin
      a = n + 1;
    end else begin
      t = n + 1;
      if (mopen[b]) begin
        push(2'b01, b, '0, t, 1'b0, 1'b0, 1'b0);
        t = t + 1 + TPC;
      end
      push(2'b00, b, p, t, 1'b0, 1'b0, 1'b0);
      a = t + 1 + TPO;
      mopen[b] = 1'b1;
      mpage[b] = p;
    end
    push({1'b1, wr}, b, PW'(l), a, 1'b1, r, wr);
    nxt_ready = a + 1 + TGAP;
    last_m = r;
  endtask

  task automatic drive(bit r, bit v, bit wr, logic [BW-1:0] b,
                       logic [PW-1:0] p, logic [LW-1:0] l);
    if (!r) begin
      bus.rq0__sched__valid = v;
      bus.rq0__sched__wr    = wr;
      bus.rq0__sched__bank  = b;
      bus.rq0__sched__page  = p;
      bus.rq0__sched__line  = l;
    end else begin
      bus.rq1__sched__valid = v;
      bus.rq1__sched__wr    = wr;
      bus.rq1__sched__bank  = b;
      bus.rq1__sched__page  = p;
      bus.rq1__sched__line  = l;
    end
  endtask

  // Poll for a grant; expects requester g granted in cycle ea
  task automatic wait_grant(string tag, bit g, int ea, output bit got);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (bus.sched__rq0__ready || bus.sched__rq1__ready) begin
        got = 1'b1;
        chk({tag, "_cyc"}, cyc, ea);
        chk({tag, "_rdy0"}, bus.sched__rq0__ready, !g);
        chk({tag, "_rdy1"}, bus.sched__rq1__ready, g);
      end
    end
    chk({tag, "_grant_seen"}, got, 1);
  endtask

  task automatic issue(string tag, bit r, bit wr, logic [BW-1:0] b,
                       logic [PW-1:0] p, logic [LW-1:0] l);
    bit got;
    int ea;
    drive(r, 1'b1, wr, b, p, l);
    ea = (cyc > nxt_ready) ? cyc : nxt_ready;
    wait_grant(tag, r, ea, got);
    if (got) model_accept(r, wr, b, p, l, cyc);
    @(posedge clk); #1;
    drive(r, 1'b0, wr, b, p, l);
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 32; i++) begin
      mopen[i] = 1'b0;
      mpage[i] = '0;
    end
    last_m = 1'b1;
    nxt_ready = 0;
  endtask

  task automatic chk_outs_zero(string tag);
    chk({tag, "_cs"}, bus.mmc__dfi__cs, 0);
    chk({tag, "_bus"}, {bus.mmc__dfi__cmd1, bus.mmc__dfi__cmd0,
                        bus.mmc__dfi__bank, bus.mmc__dfi__addr}, 0);
    chk({tag, "_issue"}, {bus.sched__issue_valid, bus.sched__issue_rq,
                          bus.sched__issue_wr}, 0);
    chk({tag, "_rdy"}, {bus.sched__rq0__ready, bus.sched__rq1__ready}, 0);
  endtask

  // Scoreboard: every cs pulse must match the oldest expected command
  always @(negedge clk) begin
    exp_t e;
    bit due;
    if (bus.mmc__dfi__cs === 1'b1) begin
      chk("cmd_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("cmd_cyc", cyc, e.cyc);
        chk("cmd_code", {bus.mmc__dfi__cmd1, bus.mmc__dfi__cmd0}, e.cmd);
        chk("cmd_bank", bus.mmc__dfi__bank, e.bank);
        chk("cmd_addr", bus.mmc__dfi__addr, e.addr);
        chk("cmd_issue", {bus.sched__issue_valid, bus.sched__issue_rq,
                          bus.sched__issue_wr}, {e.iv, e.irq, e.iwr});
      end
    end else begin
      chk("nop_bus", {bus.mmc__dfi__cs, bus.mmc__dfi__cmd1,
                      bus.mmc__dfi__cmd0, bus.mmc__dfi__bank,
                      bus.mmc__dfi__addr, bus.sched__issue_valid,
                      bus.sched__issue_rq, bus.sched__issue_wr}, 0);
      due = (q.size() != 0) && (q[0].cyc <= cyc);
      chk("cmd_due", due, 0);
      if (due) e = q.pop_front();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int ea;
    model_reset();
    rst = 1'b1;
    bus.dfi__mmc__init_done = 1'b1;
    drive(1'b0, 1'b1, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    chk_outs_zero("reset");
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(posedge clk); #1;

    // Closed bank: PO then RD after T_PO
    issue("miss_rd", 1'b0, 1'b0, 5'd3, 12'h012, 6'd5);
    // Page hit write from rq1
    issue("hit_wr", 1'b1, 1'b1, 5'd3, 12'h012, 6'd9);
    // Page conflict: PC, PO, RD
    issue("conf_rd", 1'b1, 1'b0, 5'd3, 12'h040, 6'd7);

    // Both requesters continuously valid: grants alternate
    drive(1'b0, 1'b1, 1'b0, 5'd3, 12'h040, 6'd1);
    drive(1'b1, 1'b1, 1'b1, 5'd7, 12'h055, 6'd2);
    for (int k = 0; k < 6; k++) begin
      bit g;
      g = !last_m;
      ea = (cyc > nxt_ready) ? cyc : nxt_ready;
      wait_grant("rr", g, ea, got);
      if (got) begin
        if (g) model_accept(1'b1, 1'b1, 5'd7, 12'h055, 6'd2, cyc);
        else   model_accept(1'b0, 1'b0, 5'd3, 12'h040, 6'd1, cyc);
      end
      @(posedge clk); #1;
    end

    // init_done low blocks new accepts with both requesters pending
    bus.dfi__mmc__init_done = 1'b0;
    for (int k = 0; k < 40 && cyc < nxt_ready; k++) begin
      @(posedge clk); #1;
    end
    repeat (6) begin
      @(negedge clk);
      chk("noinit_rdy0", bus.sched__rq0__ready, 0);
      chk("noinit_rdy1", bus.sched__rq1__ready, 0);
      chk("noinit_cs", bus.mmc__dfi__cs, 0);
    end
    @(posedge clk); #1;
    bus.dfi__mmc__init_done = 1'b1;
    ea = cyc;
    wait_grant("init_up", !last_m, ea, got);
    if (got) model_accept(1'b0, 1'b0, 5'd3, 12'h040, 6'd1, cyc);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);

    // Reset in PO_WAIT aborts the request and clears the page table
    issue("pre_rst", 1'b0, 1'b0, 5'd9, 12'h077, 6'd3);
    @(posedge clk); #2;
    rst = 1'b1;
    model_reset();
    drive(1'b0, 1'b1, 1'b0, 5'd9, 12'h077, 6'd3);
    #1;
    chk_outs_zero("mid_reset");
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    issue("post_rst", 1'b0, 1'b0, 5'd9, 12'h077, 6'd3);

    for (int k = 0; k < 40 && cyc <= nxt_ready + 1; k++) begin
      @(posedge clk); #1;
    end
    chk("sb_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
